// File: rtl/uart_rx_param.sv
// UART receiver: oversampled majority-vote bits, optional parity,
// one or two stop bits, line-break detection and per-bit serial tap.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 serial_out,
    output logic                 serial_valid
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_LO    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] MID_HI    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 sync1, sync2, rx_prev;
    logic [CW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, perr_pend;
    logic                 v_a, v_b;
    logic                 fall, voted, resolve, in_frame;

    assign fall     = rx_prev & ~sync2;
    assign voted    = (v_a & v_b) | (v_a & sync2) | (v_b & sync2);
    assign resolve  = sample_tick && (tick_cnt == MID_HI);
    assign in_frame = (state == S_START) || (state == S_DATA) ||
                      (state == S_PAR) || (state == S_STOP);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            perr_pend    <= 1'b0;
            v_a          <= 1'b0;
            v_b          <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            break_det    <= 1'b0;
            serial_valid <= 1'b0;
            // Bit clock free-runs across the frame; states advance mid-bit.
            if (in_frame && sample_tick) begin
                tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
                if (tick_cnt == MID_LO) v_a <= sync2;
                if (tick_cnt == MID)    v_b <= sync2;
            end
            unique case (state)
                S_IDLE: begin
                    if (fall) begin
                        state     <= S_START;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        perr_pend <= 1'b0;
                        par_bit   <= 1'b0;
                    end
                end
                S_START: begin
                    if (resolve) state <= voted ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (resolve) begin
                        shreg        <= {voted, shreg[DATA_BITS-1:1]};
                        serial_out   <= voted;
                        serial_valid <= 1'b1;
                        stop_cnt     <= 1'b0;
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (resolve) begin
                        par_bit   <= voted;
                        perr_pend <= (PARITY == 1) ? ~(^shreg ^ voted)
                                                   : (^shreg ^ voted);
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (resolve) begin
                        if (!voted || stop_cnt == LAST_STOP) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= perr_pend;
                            frame_err  <= ~voted;
                            state      <= S_IDLE;
                            if (!voted && !stop_cnt && shreg == '0 &&
                                (PARITY == 0 || !par_bit)) begin
                                break_det <= 1'b1;
                                state     <= S_WAIT_IDLE;
                                tick_cnt  <= '0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (!sync2) begin
                        tick_cnt <= '0;
                    end else if (sample_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            state    <= S_IDLE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: default receiver plus an even-parity receiver,
// 25 MHz clock with a 115200x16 sample_tick.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic [7:0] d0, d1;
    logic dv0, pe0, fe0, bk0, so0, sv0;
    logic dv1, pe1, fe1, bk1, so1, sv1;

    int checks = 0;
    int failures = 0;
    int dv_n[2];
    int bk_n[2];
    int sv_n[2];
    logic [7:0] ld[2];
    logic lp[2];
    logic lf[2];
    logic sq[2][$];
    logic [7:0] dq0[$];

    uart_rx_param u0 (
        .sys_clk(clk), .reset_n(rst_n), .sample_tick(tick), .rx_in(rx0),
        .data_out(d0), .data_valid(dv0), .parity_err(pe0),
        .frame_err(fe0), .break_det(bk0), .serial_out(so0),
        .serial_valid(sv0)
    );

    uart_rx_param #(.PARITY(2)) u1 (
        .sys_clk(clk), .reset_n(rst_n), .sample_tick(tick), .rx_in(rx1),
        .data_out(d1), .data_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .break_det(bk1), .serial_out(so1),
        .serial_valid(sv1)
    );

    always #20 clk = ~clk;

    // 1.8432 MHz / 25 MHz = 1152 / 15625
    initial begin
        int acc;
        acc = 0;
        forever begin
            @(negedge clk);
            acc = acc + 1152;
            if (acc >= 15625) begin
                acc = acc - 15625;
                tick = 1'b1;
            end else begin
                tick = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            dv_n[i] = 0; bk_n[i] = 0; sv_n[i] = 0;
            ld[i] = '0; lp[i] = 1'b0; lf[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (sv0) begin sv_n[0]++; sq[0].push_back(so0); end
            if (sv1) begin sv_n[1]++; sq[1].push_back(so1); end
            if (dv0) begin
                dv_n[0]++; ld[0] = d0; lp[0] = pe0; lf[0] = fe0;
                dq0.push_back(d0);
            end
            if (dv1) begin
                dv_n[1]++; ld[1] = d1; lp[1] = pe1; lf[1] = fe1;
            end
            if (bk0) bk_n[0]++;
            if (bk1) bk_n[1]++;
        end
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int u, input logic v, input int n);
        if (u == 0) rx0 = v;
        else rx1 = v;
        wait_ticks(n);
    endtask

    task automatic send(input int u, input logic [7:0] d, input logic hp,
                        input logic pb, input logic stop);
        drive(u, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(u, d[i], 16);
        if (hp) drive(u, pb, 16);
        drive(u, stop, 16);
        if (u == 0) rx0 = 1'b1;
        else rx1 = 1'b1;
    endtask

    typedef struct {
        int         u;
        logic [7:0] d;
        logic       pb;
        logic       stop;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        logic       eb;
    } vec_t;

    localparam int NV = 8;
    vec_t v[NV];

    initial begin
        int u, dvb, bkb, svb;
        logic [7:0] got;

        v[0] = '{0, 8'hD6, 1'b0, 1'b1, 8'hD6, 1'b0, 1'b0, 1'b0};
        v[1] = '{1, 8'h35, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
        v[2] = '{1, 8'h35, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0};
        v[3] = '{0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        v[4] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        v[5] = '{1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        v[6] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        v[7] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

        wait_ticks(5);
        chk("rst d0", int'(d0), 0);
        chk("rst flags0", int'({dv0, pe0, fe0, bk0, so0, sv0}), 0);
        chk("rst flags1", int'({dv1, pe1, fe1, bk1, so1, sv1}), 0);
        rst_n = 1'b1;
        wait_ticks(20);

        for (int k = 0; k < NV; k++) begin
            u = v[k].u;
            dvb = dv_n[u]; bkb = bk_n[u]; svb = sv_n[u];
            sq[u].delete();
            send(u, v[k].d, u == 1, v[k].pb, v[k].stop);
            wait_ticks(20);
            got = '0;
            for (int i = 0; i < 8 && i < sq[u].size(); i++) got[i] = sq[u][i];
            chk($sformatf("v%0d data_valid", k), dv_n[u] - dvb, 1);
            chk($sformatf("v%0d data_out", k), int'(ld[u]), int'(v[k].ed));
            chk($sformatf("v%0d parity_err", k), int'(lp[u]), int'(v[k].ep));
            chk($sformatf("v%0d frame_err", k), int'(lf[u]), int'(v[k].ef));
            chk($sformatf("v%0d break_det", k), bk_n[u] - bkb, int'(v[k].eb));
            chk($sformatf("v%0d serial_valid", k), sv_n[u] - svb, 8);
            chk($sformatf("v%0d serial_out", k), int'(got), int'(v[k].d));
        end

        dvb = dv_n[0]; svb = sv_n[0];
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 40);
        chk("glitch serial_valid", sv_n[0] - svb, 0);
        chk("glitch data_valid", dv_n[0] - dvb, 0);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_ticks(20);
        chk("glitch next dv", dv_n[0] - dvb, 1);
        chk("glitch next data", int'(ld[0]), 8'h5A);

        dvb = dv_n[0]; bkb = bk_n[0];
        drive(0, 1'b0, 192);
        drive(0, 1'b1, 8);
        drive(0, 1'b0, 160);
        drive(0, 1'b1, 20);
        chk("break dv", dv_n[0] - dvb, 1);
        chk("break pulse", bk_n[0] - bkb, 1);
        chk("break data", int'(ld[0]), 0);
        chk("break frame_err", int'(lf[0]), 1);
        send(0, 8'h35, 1'b0, 1'b0, 1'b1);
        wait_ticks(20);
        chk("post-break dv", dv_n[0] - dvb, 2);
        chk("post-break data", int'(ld[0]), 8'h35);
        chk("post-break frame_err", int'(lf[0]), 0);
        chk("post-break no break", bk_n[0] - bkb, 1);

        dvb = dv_n[0];
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 64);
        rst_n = 1'b0;
        wait_ticks(3);
        chk("midreset data_out", int'(d0), 0);
        rst_n = 1'b1;
        wait_ticks(20);
        send(0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_ticks(20);
        chk("midreset dv", dv_n[0] - dvb, 1);
        chk("midreset data", int'(ld[0]), 8'h12);
        chk("midreset flags", int'({lp[0], lf[0]}), 0);

        dq0.delete();
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_ticks(20);
        chk("b2b count", dq0.size(), 2);
        if (dq0.size() == 2) begin
            chk("b2b first", int'(dq0[0]), 8'h3C);
            chk("b2b second", int'(dq0[1]), 8'hC3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
